alu_rs_pool: RTL and testbench

Multi-entry reservation station with an integrated ALU for the Tomasulo core. It replaces the single-entry ALU station with ENTRIES slots that snoop the CDB for pending operands. Each cycle it dispatches the oldest ready slot to a one-cycle add/sub path or a multi-cycle multiplier, and presents results on a registered valid/ready port. The port feeds the CDB arbiter, tagged with the reorder-buffer index.

---
 rtl/alu_rs_pkg.sv | 43 ++++
 rtl/alu_rs_mul.sv | 72 +++++++
 rtl/alu_rs_pool.sv | 209 ++++++++++++++++++++
 tb/tb_alu_rs_pool.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_rs_pkg.sv
// Shared definitions for the ALU reservation-station pool: opcodes, the
// reorder-buffer tag sentinels and the station slot record.
// The slot record is sized for the default pool widths
// (WORD_SIZE=32, RB_INDEX=4, OPCODE_WIDTH=6).
package alu_rs_pkg;

  localparam int PKG_WORD_W = 32;
  localparam int PKG_RB_W   = 4;
  localparam int PKG_OP_W   = 6;
  localparam int PKG_AGE_W  = 8;

  localparam logic [PKG_OP_W-1:0] INST_ADD  = 6'd0;
  localparam logic [PKG_OP_W-1:0] INST_ADDI = 6'd1;
  localparam logic [PKG_OP_W-1:0] INST_SUB  = 6'd2;
  localparam logic [PKG_OP_W-1:0] INST_SUBI = 6'd3;
  localparam logic [PKG_OP_W-1:0] INST_MUL  = 6'd4;
  localparam logic [PKG_OP_W-1:0] INST_MULI = 6'd5;

  // Tag meaning "operand value already present"; lane 15 is never snooped.
  localparam logic [PKG_RB_W-1:0] RB_READY = 4'hF;
  // Tag shown on the output port while it holds no result.
  localparam logic [PKG_RB_W-1:0] RB_NULL  = 4'h0;

  typedef struct packed {
    logic                  busy;
    logic [PKG_OP_W-1:0]   op;
    logic [PKG_RB_W-1:0]   dest;
    logic [PKG_WORD_W-1:0] vj;
    logic [PKG_RB_W-1:0]   qj;
    logic [PKG_WORD_W-1:0] vk;
    logic [PKG_RB_W-1:0]   qk;
    logic [PKG_AGE_W-1:0]  age;   // 0 = oldest occupied slot
  } slot_t;

  function automatic logic op_is_mul(input logic [PKG_OP_W-1:0] op);
    return (op == INST_MUL) || (op == INST_MULI);
  endfunction

  function automatic logic op_is_sub(input logic [PKG_OP_W-1:0] op);
    return (op == INST_SUB) || (op == INST_SUBI);
  endfunction

endpackage

// File: rtl/alu_rs_mul.sv
// Multi-cycle multiplier for the ALU station pool. The product is captured
// at start; done_o is asserted on the cycle the result is handed to the
// output register, which only happens while that register is free.
module alu_rs_mul #(
  parameter int WORD_SIZE = 32,
  parameter int RB_INDEX  = 4,
  parameter int MUL_LAT   = 3
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 flush_i,
  input  logic                 start_i,
  input  logic [WORD_SIZE-1:0] a_i,
  input  logic [WORD_SIZE-1:0] b_i,
  input  logic [RB_INDEX-1:0]  tag_i,
  input  logic                 out_free_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [WORD_SIZE-1:0] result_o,
  output logic [RB_INDEX-1:0]  tag_o
);

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WORD_SIZE-1:0] result_q;
  logic [RB_INDEX-1:0]  tag_q;

  assign busy_o   = (state_q == S_BUSY);
  assign done_o   = (state_q == S_BUSY) && (cnt_q == '0) && out_free_i;
  assign result_o = result_q;
  assign tag_o    = tag_q;

  // Latency countdown; a finished product waits in BUSY until the output frees up.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_IDLE) begin
      if (start_i) begin
        state_d = S_BUSY;
        cnt_d   = CNT_W'(MUL_LAT - 1);
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else if (out_free_i) begin
      state_d = S_IDLE;
    end
  end

  // Control state, squashed by reset or flush.
  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operand product and tag captured when a multiply is accepted.
  always_ff @(posedge clk_i) begin
    if (start_i && (state_q == S_IDLE)) begin
      result_q <= a_i * b_i;
      tag_q    <= tag_i;
    end
  end

endmodule

// File: rtl/alu_rs_pool.sv
// Multi-entry ALU reservation station with integrated add/sub and a
// multi-cycle multiplier. Slots snoop the CDB for pending operands; each
// cycle the oldest eligible ready slot is dispatched.
// Optional feature macro: ALU_RS_BYPASS_EN -- capture a source operand
// from the CDB in the same cycle the instruction is issued.
module alu_rs_pool
  import alu_rs_pkg::*;
#(
  parameter int ENTRIES      = 4,
  parameter int WORD_SIZE    = 32,
  parameter int RB_INDEX     = 4,
  parameter int RB_SIZE      = 16,
  parameter int OPCODE_WIDTH = 6,
  parameter int MUL_LAT      = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         issue_valid,
  output logic                         issue_ready,
  input  logic [OPCODE_WIDTH-1:0]      issue_op,
  input  logic [RB_INDEX-1:0]          issue_dest,
  input  logic [WORD_SIZE-1:0]         issue_vj,
  input  logic [WORD_SIZE-1:0]         issue_vk,
  input  logic [RB_INDEX-1:0]          issue_qj,
  input  logic [RB_INDEX-1:0]          issue_qk,
  input  logic [WORD_SIZE*RB_SIZE-1:0] cdb_data,
  input  logic [RB_SIZE-1:0]           cdb_valid,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WORD_SIZE-1:0]         out_data,
  output logic [RB_INDEX-1:0]          out_dest
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int AGE_W = PKG_AGE_W;

  slot_t                slot_q [ENTRIES];
  slot_t                slot_d [ENTRIES];
  logic                 issue_ready_q, issue_ready_d;
  logic                 out_valid_q;
  logic [WORD_SIZE-1:0] out_data_q;
  logic [RB_INDEX-1:0]  out_dest_q;

  logic                 mul_busy, mul_done;
  logic [WORD_SIZE-1:0] mul_res;
  logic [RB_INDEX-1:0]  mul_dest;

  logic                 out_free;
  logic                 sel_found;
  logic [IDX_W-1:0]     sel_idx;
  logic [AGE_W-1:0]     sel_age;
  logic                 free_found;
  logic [IDX_W-1:0]     free_idx;
  logic [AGE_W-1:0]     busy_cnt;
  logic                 disp, disp_mul, disp_alu, issue_fire;
  slot_t                sel_slot;
  logic [WORD_SIZE-1:0] alu_res;

  function automatic logic [WORD_SIZE-1:0] cdb_lane(input logic [RB_INDEX-1:0] tag);
    return cdb_data[int'(tag)*WORD_SIZE +: WORD_SIZE];
  endfunction

  assign out_free = !out_valid_q || out_ready;

  // Oldest ready slot whose execution unit can take it this cycle.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_age   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (slot_q[i].busy && (slot_q[i].qj == RB_READY) && (slot_q[i].qk == RB_READY) &&
          (op_is_mul(slot_q[i].op) ? !mul_busy : (out_free && !mul_done)) &&
          (!sel_found || (slot_q[i].age < sel_age))) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_age   = slot_q[i].age;
      end
    end
  end

  // Lowest free slot for issue, plus occupancy for age assignment.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    busy_cnt   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (slot_q[i].busy) begin
        busy_cnt = busy_cnt + AGE_W'(1);
      end else if (!free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign sel_slot   = slot_q[sel_idx];
  assign disp       = sel_found && !flush;
  assign disp_mul   = disp && op_is_mul(sel_slot.op);
  assign disp_alu   = disp && !op_is_mul(sel_slot.op);
  assign issue_fire = issue_valid && issue_ready_q && free_found && !flush;
  assign alu_res    = op_is_sub(sel_slot.op) ? (sel_slot.vj - sel_slot.vk)
                                             : (sel_slot.vj + sel_slot.vk);

  // Slot array next state: snoop, dispatch/age compaction, issue, flush.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      slot_d[i] = slot_q[i];
      if (slot_q[i].busy && (slot_q[i].qj != RB_READY) && cdb_valid[slot_q[i].qj]) begin
        slot_d[i].vj = cdb_lane(slot_q[i].qj);
        slot_d[i].qj = RB_READY;
      end
      if (slot_q[i].busy && (slot_q[i].qk != RB_READY) && cdb_valid[slot_q[i].qk]) begin
        slot_d[i].vk = cdb_lane(slot_q[i].qk);
        slot_d[i].qk = RB_READY;
      end
      if (disp && (sel_idx == IDX_W'(i))) begin
        slot_d[i].busy = 1'b0;
      end else if (disp && slot_q[i].busy && (slot_q[i].age > sel_age)) begin
        slot_d[i].age = slot_q[i].age - AGE_W'(1);
      end
      if (issue_fire && (free_idx == IDX_W'(i))) begin
        slot_d[i].busy = 1'b1;
        slot_d[i].op   = issue_op;
        slot_d[i].dest = issue_dest;
        slot_d[i].vj   = issue_vj;
        slot_d[i].qj   = issue_qj;
        slot_d[i].vk   = issue_vk;
        slot_d[i].qk   = issue_qk;
        slot_d[i].age  = busy_cnt - AGE_W'(disp);
`ifdef ALU_RS_BYPASS_EN
        if ((issue_qj != RB_READY) && cdb_valid[issue_qj]) begin
          slot_d[i].vj = cdb_lane(issue_qj);
          slot_d[i].qj = RB_READY;
        end
        if ((issue_qk != RB_READY) && cdb_valid[issue_qk]) begin
          slot_d[i].vk = cdb_lane(issue_qk);
          slot_d[i].qk = RB_READY;
        end
`endif
      end
      if (flush) begin
        slot_d[i].busy = 1'b0;
      end
    end
  end

  // issue_ready reflects occupancy after this edge.
  always_comb begin
    issue_ready_d = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!slot_d[i].busy) issue_ready_d = 1'b1;
    end
  end

  // Slot storage; only the busy bits and issue_ready are reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      slot_q[i] <= slot_d[i];
      if (reset) slot_q[i].busy <= 1'b0;
    end
    issue_ready_q <= reset ? 1'b1 : issue_ready_d;
  end

  // Output register: multiplier completion has priority over add/sub.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_dest_q  <= RB_NULL;
    end else if (mul_done) begin
      out_valid_q <= 1'b1;
      out_data_q  <= mul_res;
      out_dest_q  <= mul_dest;
    end else if (disp_alu) begin
      out_valid_q <= 1'b1;
      out_data_q  <= alu_res;
      out_dest_q  <= sel_slot.dest;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
      out_dest_q  <= RB_NULL;
    end
  end

  alu_rs_mul #(
    .WORD_SIZE (WORD_SIZE),
    .RB_INDEX  (RB_INDEX),
    .MUL_LAT   (MUL_LAT)
  ) u_mul (
    .clk_i      (clk),
    .reset_i    (reset),
    .flush_i    (flush),
    .start_i    (disp_mul),
    .a_i        (sel_slot.vj),
    .b_i        (sel_slot.vk),
    .tag_i      (sel_slot.dest),
    .out_free_i (out_free),
    .busy_o     (mul_busy),
    .done_o     (mul_done),
    .result_o   (mul_res),
    .tag_o      (mul_dest)
  );

  assign issue_ready = issue_ready_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_dest    = out_dest_q;

endmodule

// File: tb/tb_alu_rs_pool.sv
// Self-checking bench for alu_rs_pool: directed scenarios followed by a
// randomized phase scored against a tag-indexed result model.
module tb_alu_rs_pool;
  import alu_rs_pkg::*;

  localparam int ENTRIES = 4;
  localparam int WORD    = 32;
  localparam int RBI     = 4;
  localparam int RBS     = 16;
  localparam int OPW     = 6;
  localparam int MUL_LAT = 3;

  logic             clk = 1'b0;
  logic             reset, flush;
  logic             issue_valid, issue_ready;
  logic [OPW-1:0]   issue_op;
  logic [RBI-1:0]   issue_dest, issue_qj, issue_qk;
  logic [WORD-1:0]  issue_vj, issue_vk;
  logic [WORD*RBS-1:0] cdb_data;
  logic [RBS-1:0]   cdb_valid;
  logic             out_valid, out_ready;
  logic [WORD-1:0]  out_data;
  logic [RBI-1:0]   out_dest;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  alu_rs_pool #(
    .ENTRIES(ENTRIES), .WORD_SIZE(WORD), .RB_INDEX(RBI), .RB_SIZE(RBS),
    .OPCODE_WIDTH(OPW), .MUL_LAT(MUL_LAT)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_dest(issue_dest), .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_qj(issue_qj), .issue_qk(issue_qk),
    .cdb_data(cdb_data), .cdb_valid(cdb_valid),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_dest(out_dest)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int t, input logic [WORD-1:0] v, input logic vld);
    cdb_data[t*WORD +: WORD] = v;
    cdb_valid[t] = vld;
  endtask

  task automatic cdb_idle();
    for (int t = 0; t < RBS; t++) set_lane(t, 32'hBAD0_0000 | t, 1'b0);
  endtask

  task automatic drive_issue(input logic [OPW-1:0] op, input logic [RBI-1:0] dest,
                             input logic [WORD-1:0] vj, input logic [RBI-1:0] qj,
                             input logic [WORD-1:0] vk, input logic [RBI-1:0] qk);
    issue_valid = 1'b1;
    issue_op = op; issue_dest = dest;
    issue_vj = vj; issue_qj = qj; issue_vk = vk; issue_qk = qk;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [WORD-1:0] d,
                            input logic [RBI-1:0] dst);
    check_eq({tag, "_vld"}, out_valid, v);
    if (v) begin
      check_eq({tag, "_data"}, out_data, d);
      check_eq({tag, "_dest"}, out_dest, dst);
    end else begin
      check_eq({tag, "_dest"}, out_dest, RB_NULL);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; issue_valid = 1'b0; out_ready = 1'b1;
    drive_issue(INST_ADD, 0, 0, RB_READY, 0, RB_READY);
    issue_valid = 1'b0;
    cdb_idle();
    tick(); tick();
    reset = 1'b0;
  endtask

  // Random-phase model: expected result per outstanding destination tag.
  logic [WORD-1:0] prod_val [RBS];
  bit              pending  [RBS];
  logic [WORD-1:0] exp_data [RBS];
  int              issued = 0;
  int              delivered = 0;

  function automatic int pending_cnt();
    int n = 0;
    for (int t = 0; t < RBS; t++) if (pending[t]) n++;
    return n;
  endfunction

  task automatic rnd_step(input bit allow_issue, input bit all_cdb);
    logic [OPW-1:0]  op;
    logic [RBI-1:0]  qj, qk;
    logic [WORD-1:0] vj, vk, a, b, res;
    int d;
    cdb_idle();
    for (int t = 8; t < 15; t++) begin
      if (all_cdb || ($urandom_range(3) == 0)) set_lane(t, prod_val[t], 1'b1);
      else set_lane(t, ~prod_val[t], 1'b0);
    end
    out_ready = all_cdb ? 1'b1 : ($urandom_range(9) < 7);
    if (!out_valid) check_eq("rnd_null", out_dest, RB_NULL);
    if (out_valid && out_ready) begin
      check_eq("rnd_known", pending[out_dest], 1);
      check_eq("rnd_data", out_data, exp_data[out_dest]);
      pending[out_dest] = 0;
      delivered++;
    end
    issue_valid = 1'b0;
    d = -1;
    for (int t = 0; t < 8; t++) if (!pending[t] && d < 0) d = t;
    if (allow_issue && d >= 0 && $urandom_range(1) == 1) begin
      case ($urandom_range(5))
        0: op = INST_ADD;  1: op = INST_ADDI; 2: op = INST_SUB;
        3: op = INST_SUBI; 4: op = INST_MUL;  default: op = INST_MULI;
      endcase
      vj = $urandom; vk = $urandom;
      qj = ($urandom_range(1) == 1) ? RB_READY : RBI'(8 + $urandom_range(6));
      qk = ($urandom_range(1) == 1) ? RB_READY : RBI'(8 + $urandom_range(6));
      a = (qj == RB_READY) ? vj : prod_val[qj];
      b = (qk == RB_READY) ? vk : prod_val[qk];
      if (op == INST_MUL || op == INST_MULI)      res = a * b;
      else if (op == INST_SUB || op == INST_SUBI) res = a - b;
      else                                        res = a + b;
      drive_issue(op, RBI'(d), vj, qj, vk, qk);
      if (issue_ready) begin
        pending[d] = 1; exp_data[d] = res; issued++;
      end
    end
    tick();
  endtask

  logic [RBI-1:0]  acc_q [$];
  logic [RBI-1:0]  got_dest_q [$];
  logic [WORD-1:0] got_data_q [$];
  logic [RBI-1:0]  age_dest [4];
  logic [WORD-1:0] age_val  [4];
  int d_cyc, hit_cyc;

  initial begin
    do_reset();
    check_eq("rst_issue_ready", issue_ready, 1);
    expect_out("rst", 1'b0, 0, RB_NULL);
    check_eq("rst_data", out_data, 0);

    // Back-to-back ADDI then SUB
    drive_issue(INST_ADDI, 1, 5, RB_READY, 3, RB_READY); tick();
    expect_out("b2b_empty", 1'b0, 0, RB_NULL);
    drive_issue(INST_SUB, 2, 10, RB_READY, 4, RB_READY); tick();
    issue_valid = 1'b0;
    expect_out("b2b_add", 1'b1, 8, 1);
    tick(); expect_out("b2b_sub", 1'b1, 6, 2);
    tick(); expect_out("b2b_drain", 1'b0, 0, RB_NULL);

    // Dependency on tag 3
    drive_issue(INST_ADD, 4, 32'h1234, 3, 2, RB_READY);
`ifdef ALU_RS_BYPASS_EN
    set_lane(3, 7, 1'b1); tick();
    issue_valid = 1'b0; cdb_idle();
    expect_out("dep_wait", 1'b0, 0, RB_NULL);
    tick(); expect_out("dep_res", 1'b1, 9, 4);
`else
    tick(); issue_valid = 1'b0;
    set_lane(3, 7, 1'b1); tick(); cdb_idle();
    expect_out("dep_wait", 1'b0, 0, RB_NULL);
    tick(); expect_out("dep_res", 1'b1, 9, 4);
`endif
    tick();

    // Oldest-first with slot reuse out of index order
    drive_issue(INST_ADD, 8, 0, 6, 1, RB_READY); tick();
    drive_issue(INST_ADD, 9, 0, 5, 10, RB_READY); tick();
    drive_issue(INST_SUB, 10, 0, 5, 20, RB_READY); tick();
    drive_issue(INST_ADD, 11, 0, 5, 30, RB_READY); tick();
    issue_valid = 1'b0;
    check_eq("age_full", issue_ready, 0);
    set_lane(6, 50, 1'b1); tick(); cdb_idle();
    tick(); expect_out("age_x", 1'b1, 51, 8);
    check_eq("age_reissue_rdy", issue_ready, 1);
    drive_issue(INST_ADD, 12, 0, 5, 40, RB_READY); tick();
    issue_valid = 1'b0;
    check_eq("age_full2", issue_ready, 0);
    set_lane(5, 100, 1'b1); tick(); cdb_idle();
    age_dest = '{9, 10, 11, 12};
    age_val  = '{110, 80, 130, 140};
    for (int k = 0; k < 4; k++) begin
      tick(); expect_out($sformatf("age%0d", k), 1'b1, age_val[k], age_dest[k]);
    end
    tick();

    // Multiplier latency: ADD overtakes MUL
    drive_issue(INST_MULI, 1, 7, RB_READY, 6, RB_READY); tick();
    drive_issue(INST_ADD, 2, 1, RB_READY, 1, RB_READY); tick();
    issue_valid = 1'b0; d_cyc = cyc;
    tick(); expect_out("mul_add_first", 1'b1, 2, 2);
    hit_cyc = -1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (out_valid && out_dest == 1) begin hit_cyc = cyc; break; end
    end
    check_eq("mul_lat", hit_cyc - d_cyc, MUL_LAT);
    check_eq("mul_data", out_data, 42);
    tick();

    // Backpressure stalls MUL; MUL completion beats a ready ADD
    out_ready = 1'b0;
    drive_issue(INST_MULI, 1, 7, RB_READY, 6, RB_READY); tick();
    drive_issue(INST_ADD, 2, 1, RB_READY, 1, RB_READY); tick();
    drive_issue(INST_ADD, 3, 3, RB_READY, 4, RB_READY); tick();
    issue_valid = 1'b0;
    expect_out("stall_add", 1'b1, 2, 2);
    for (int k = 0; k < 5; k++) begin
      tick(); expect_out("stall_hold", 1'b1, 2, 2);
    end
    out_ready = 1'b1;
    tick(); expect_out("stall_mul", 1'b1, 42, 1);
    tick(); expect_out("stall_add2", 1'b1, 7, 3);
    tick(); expect_out("stall_drain", 1'b0, 0, RB_NULL);

    // Full station under backpressure
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      drive_issue(INST_ADD, RBI'(k), k * 3, RB_READY, 1000, RB_READY);
      if (issue_ready) acc_q.push_back(RBI'(k));
      tick();
    end
    issue_valid = 1'b0;
    check_eq("full_accepted", acc_q.size(), ENTRIES + 1);
    check_eq("full_rdy_low", issue_ready, 0);
    out_ready = 1'b1;
    if (out_valid) begin got_dest_q.push_back(out_dest); got_data_q.push_back(out_data); end
    for (int k = 0; k < 12; k++) begin
      tick();
      if (out_valid) begin got_dest_q.push_back(out_dest); got_data_q.push_back(out_data); end
    end
    check_eq("full_delivered", got_dest_q.size(), ENTRIES + 1);
    for (int k = 0; k < ENTRIES + 1 && k < got_dest_q.size(); k++) begin
      check_eq($sformatf("full_dest%0d", k), got_dest_q[k], RBI'(k));
      check_eq($sformatf("full_data%0d", k), got_data_q[k], k * 3 + 1000);
    end
    check_eq("full_rdy_back", issue_ready, 1);

    // Flush while the multiplier is busy
    drive_issue(INST_MULI, 5, 9, RB_READY, 9, RB_READY); tick();
    issue_valid = 1'b0; tick(); tick();
    flush = 1'b1;
    drive_issue(INST_ADD, 6, 1, RB_READY, 1, RB_READY); tick();
    flush = 1'b0; issue_valid = 1'b0;
    expect_out("flush_out", 1'b0, 0, RB_NULL);
    check_eq("flush_rdy", issue_ready, 1);
    for (int k = 0; k < 6; k++) begin
      tick(); check_eq("flush_no_stale", out_valid, 0);
    end
    drive_issue(INST_ADD, 7, 1, RB_READY, 2, RB_READY); tick();
    issue_valid = 1'b0;
    tick(); expect_out("post_flush", 1'b1, 3, 7);
    tick();

    // Randomized traffic
    do_reset();
    for (int t = 0; t < RBS; t++) begin
      prod_val[t] = $urandom; pending[t] = 0; exp_data[t] = '0;
    end
    for (int k = 0; k < 600; k++) rnd_step(1'b1, 1'b0);
    for (int k = 0; k < 300 && pending_cnt() != 0; k++) rnd_step(1'b0, 1'b1);
    check_eq("rnd_drain", pending_cnt(), 0);
    check_eq("rnd_count", delivered, issued);
    cdb_idle(); tick();
    check_eq("rnd_rdy_end", issue_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
